// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS datapath: word width, ALU
// operation codes, B-operand selects and the immediate sign-extension helper.
package mc_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_sel_e;

  function automatic logic [WORD_W-1:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, register 0 hardwired to zero, optional synchronous clear on reset.
module mc_regfile
  import mc_pkg::*;
#(
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [4:0]        i_ra1,
  input  logic [4:0]        i_ra2,
  output logic [WORD_W-1:0] o_rd1,
  output logic [WORD_W-1:0] o_rd2,
  input  logic              i_we,
  input  logic [4:0]        i_wa,
  input  logic [WORD_W-1:0] i_wd
);

  logic [WORD_W-1:0] r_mem [0:31];

  // Reset suppresses any write in the same cycle, whether or not it clears.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (CLEAR_ON_RST) begin
        for (int i = 0; i < 32; i++) begin
          r_mem[i] <= {WORD_W{1'b0}};
        end
      end
    end else if (i_we && (i_wa != 5'd0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? {WORD_W{1'b0}} : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? {WORD_W{1'b0}} : r_mem[i_ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath driven by an external control unit.
// Optional MC_DATAPATH_JUMP_EN adds a Jump input for J-type PC targets.
module mc_datapath
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          RF_CLEAR_ON_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemtoReg,
  input  logic        RegDst,
  input  logic        IorD,
  input  logic        PCSrc,
  input  logic        ALUSrcA,
  input  logic        IRWrite,
  input  logic        MemWrite,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic        RegWrite,
`ifdef MC_DATAPATH_JUMP_EN
  input  logic        Jump,
`endif
  input  logic [1:0]  ALUSrcB,
  input  logic [2:0]  ALUControl,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic        Zero,
  output logic [31:0] pc
);

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_ir;
  logic [WORD_W-1:0] r_data;
  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_b;
  logic [WORD_W-1:0] r_aluout;

  logic [WORD_W-1:0] w_rd1;
  logic [WORD_W-1:0] w_rd2;
  logic [WORD_W-1:0] w_sign_imm;
  logic [WORD_W-1:0] w_src_a;
  logic [WORD_W-1:0] w_src_b;
  logic [WORD_W-1:0] w_alu_result;
  logic [WORD_W-1:0] w_pc_next;
  logic [WORD_W-1:0] w_rf_wd;
  logic [4:0]        w_rf_wa;
  logic              w_pc_en;

  assign w_sign_imm = sign_ext16(r_ir[15:0]);
  assign w_src_a    = ALUSrcA ? r_a : r_pc;
  assign w_rf_wa    = RegDst ? r_ir[15:11] : r_ir[20:16];
  assign w_rf_wd    = MemtoReg ? r_data : r_aluout;
  assign w_pc_en    = PCWrite | (Branch & Zero);

  assign mem_addr  = IorD ? r_aluout : r_pc;
  assign mem_wdata = r_b;
  assign mem_we    = MemWrite & ~rst;
  assign Opcode    = r_ir[31:26];
  assign Funct     = r_ir[5:0];
  assign Zero      = (w_alu_result == 32'h0000_0000);
  assign pc        = r_pc;

  mc_regfile #(
    .CLEAR_ON_RST(RF_CLEAR_ON_RST)
  ) u_regfile (
    .i_clk (clk),
    .i_rst (rst),
    .i_ra1 (r_ir[25:21]),
    .i_ra2 (r_ir[20:16]),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (RegWrite),
    .i_wa  (w_rf_wa),
    .i_wd  (w_rf_wd)
  );

  // ALU B-operand select.
  always_comb begin
    w_src_b = r_b;
    case (ALUSrcB)
      SRCB_REG:     w_src_b = r_b;
      SRCB_FOUR:    w_src_b = 32'd4;
      SRCB_IMM:     w_src_b = w_sign_imm;
      SRCB_IMM_SH2: w_src_b = {w_sign_imm[29:0], 2'b00};
      default:      w_src_b = r_b;
    endcase
  end

  // ALU; unassigned operation codes yield zero, slt compares as signed.
  always_comb begin
    w_alu_result = 32'h0000_0000;
    case (ALUControl)
      ALU_ADD: w_alu_result = w_src_a + w_src_b;
      ALU_SUB: w_alu_result = w_src_a - w_src_b;
      ALU_AND: w_alu_result = w_src_a & w_src_b;
      ALU_OR:  w_alu_result = w_src_a | w_src_b;
      ALU_SLT: w_alu_result = ($signed(w_src_a) < $signed(w_src_b)) ? 32'd1 : 32'd0;
      default: w_alu_result = 32'h0000_0000;
    endcase
  end

  // Next-PC select; a jump outranks the PCSrc choice when enabled.
  always_comb begin
    w_pc_next = w_alu_result;
`ifdef MC_DATAPATH_JUMP_EN
    if (Jump && PCWrite) begin
      w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
    end else if (PCSrc) begin
      w_pc_next = r_aluout;
    end else begin
      w_pc_next = w_alu_result;
    end
`else
    if (PCSrc) begin
      w_pc_next = r_aluout;
    end else begin
      w_pc_next = w_alu_result;
    end
`endif
  end

  // Architectural state; Data/A/B/ALUOut capture every cycle, IR and PC are gated.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_ir     <= 32'h0000_0000;
      r_data   <= 32'h0000_0000;
      r_a      <= 32'h0000_0000;
      r_b      <= 32'h0000_0000;
      r_aluout <= 32'h0000_0000;
    end else begin
      r_data   <= mem_rdata;
      r_a      <= w_rd1;
      r_b      <= w_rd2;
      r_aluout <= w_alu_result;
      if (IRWrite) begin
        r_ir <= mem_rdata;
      end
      if (w_pc_en) begin
        r_pc <= w_pc_next;
      end
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed-vector bench for mc_datapath: one table row per clock cycle,
// giving control strobes, memory read data and the outputs expected before the edge.
module tb_mc_datapath;

  logic        clk;
  logic        rst;
  logic        MemtoReg, RegDst, IorD, PCSrc, ALUSrcA, IRWrite;
  logic        MemWrite, PCWrite, Branch, RegWrite;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic        Zero;
  logic [31:0] pc;
`ifdef MC_DATAPATH_JUMP_EN
  logic        Jump;
`endif

  // ctrl bit order: rst MemtoReg RegDst IorD PCSrc ALUSrcA IRWrite MemWrite PCWrite Branch RegWrite
  localparam logic [10:0] C_NONE  = 11'h000;
  localparam logic [10:0] C_RST   = 11'h400;
  localparam logic [10:0] C_MTR   = 11'h200;
  localparam logic [10:0] C_RDST  = 11'h100;
  localparam logic [10:0] C_IORD  = 11'h080;
  localparam logic [10:0] C_PCSRC = 11'h040;
  localparam logic [10:0] C_ASRCA = 11'h020;
  localparam logic [10:0] C_IRW   = 11'h010;
  localparam logic [10:0] C_MEMW  = 11'h008;
  localparam logic [10:0] C_PCW   = 11'h004;
  localparam logic [10:0] C_BR    = 11'h002;
  localparam logic [10:0] C_REGW  = 11'h001;

  typedef struct {
    logic [10:0] ctrl;
    logic [1:0]  srcb;
    logic [2:0]  alu;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_we;
    logic        e_zero;
    logic [31:0] e_pc;
    logic [5:0]  e_op;
    logic [5:0]  e_fn;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl [40];
  vec_t h;

  mc_datapath #(
    .RESET_PC        (32'h0000_0100),
    .RF_CLEAR_ON_RST (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .IorD       (IorD),
    .PCSrc      (PCSrc),
    .ALUSrcA    (ALUSrcA),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .RegWrite   (RegWrite),
`ifdef MC_DATAPATH_JUMP_EN
    .Jump       (Jump),
`endif
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .Opcode     (Opcode),
    .Funct      (Funct),
    .Zero       (Zero),
    .pc         (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int idx, input string what, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, what, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and check outputs before the rising edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    {rst, MemtoReg, RegDst, IorD, PCSrc, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite} = v.ctrl;
    ALUSrcB    = v.srcb;
    ALUControl = v.alu;
    mem_rdata  = v.rdata;
    #1;
    n_vec++;
    check(idx, "mem_addr",  mem_addr,            v.e_addr);
    check(idx, "mem_wdata", mem_wdata,           v.e_wdata);
    check(idx, "mem_we",    {31'd0, mem_we},     {31'd0, v.e_we});
    check(idx, "Zero",      {31'd0, Zero},       {31'd0, v.e_zero});
    check(idx, "pc",        pc,                  v.e_pc);
    check(idx, "Opcode",    {26'd0, Opcode},     {26'd0, v.e_op});
    check(idx, "Funct",     {26'd0, Funct},      {26'd0, v.e_fn});
  endtask

  initial begin
    // reset state, addi $8,$0,5 and the no-bypass read of $8
    tbl[0]  = '{C_NONE,                      2'b00, 3'b000, 32'h0000_0000, 32'h100, 32'h0, 1'b0, 1'b1, 32'h100, 6'h00, 6'h00};
    tbl[1]  = '{C_IRW | C_PCW,               2'b01, 3'b010, 32'h2008_0005, 32'h100, 32'h0, 1'b0, 1'b0, 32'h100, 6'h00, 6'h00};
    tbl[2]  = '{C_ASRCA,                     2'b10, 3'b010, 32'h0000_0000, 32'h104, 32'h0, 1'b0, 1'b0, 32'h104, 6'h08, 6'h05};
    tbl[3]  = '{C_REGW,                      2'b00, 3'b011, 32'h0000_0000, 32'h104, 32'h0, 1'b0, 1'b1, 32'h104, 6'h08, 6'h05};
    tbl[4]  = '{C_NONE,                      2'b00, 3'b000, 32'h0000_0000, 32'h104, 32'h0, 1'b0, 1'b1, 32'h104, 6'h08, 6'h05};
    tbl[5]  = '{C_NONE,                      2'b00, 3'b000, 32'h0000_0000, 32'h104, 32'h5, 1'b0, 1'b0, 32'h104, 6'h08, 6'h05};
    // addi $9,$0,5
    tbl[6]  = '{C_IRW | C_PCW,               2'b01, 3'b010, 32'h2009_0005, 32'h104, 32'h5, 1'b0, 1'b0, 32'h104, 6'h08, 6'h05};
    tbl[7]  = '{C_ASRCA,                     2'b10, 3'b010, 32'h0000_0000, 32'h108, 32'h5, 1'b0, 1'b0, 32'h108, 6'h08, 6'h05};
    tbl[8]  = '{C_REGW,                      2'b00, 3'b011, 32'h0000_0000, 32'h108, 32'h0, 1'b0, 1'b1, 32'h108, 6'h08, 6'h05};
    // beq $8,$9 to 0x200 taken
    tbl[9]  = '{C_IRW | C_PCW,               2'b01, 3'b010, 32'h1109_003D, 32'h108, 32'h0, 1'b0, 1'b0, 32'h108, 6'h08, 6'h05};
    tbl[10] = '{C_NONE,                      2'b11, 3'b010, 32'h0000_0000, 32'h10C, 32'h5, 1'b0, 1'b0, 32'h10C, 6'h04, 6'h3D};
    tbl[11] = '{C_ASRCA | C_BR | C_PCSRC,    2'b00, 3'b110, 32'h0000_0000, 32'h10C, 32'h5, 1'b0, 1'b1, 32'h10C, 6'h04, 6'h3D};
    tbl[12] = '{C_NONE,                      2'b00, 3'b000, 32'h0000_0000, 32'h200, 32'h5, 1'b0, 1'b1, 32'h200, 6'h04, 6'h3D};
    // $9 <= 6 from memory data, then branch not taken
    tbl[13] = '{C_NONE,                      2'b00, 3'b000, 32'h0000_0006, 32'h200, 32'h5, 1'b0, 1'b1, 32'h200, 6'h04, 6'h3D};
    tbl[14] = '{C_REGW | C_MTR,              2'b00, 3'b000, 32'h0000_0000, 32'h200, 32'h5, 1'b0, 1'b1, 32'h200, 6'h04, 6'h3D};
    tbl[15] = '{C_NONE,                      2'b00, 3'b000, 32'h0000_0000, 32'h200, 32'h5, 1'b0, 1'b1, 32'h200, 6'h04, 6'h3D};
    tbl[16] = '{C_ASRCA | C_BR | C_PCSRC,    2'b00, 3'b110, 32'h0000_0000, 32'h200, 32'h6, 1'b0, 1'b0, 32'h200, 6'h04, 6'h3D};
    tbl[17] = '{C_NONE,                      2'b00, 3'b000, 32'h0000_0000, 32'h200, 32'h6, 1'b0, 1'b1, 32'h200, 6'h04, 6'h3D};
    // write 0xDEADBEEF to $0 via rd
    tbl[18] = '{C_NONE,                      2'b00, 3'b000, 32'hDEAD_BEEF, 32'h200, 32'h6, 1'b0, 1'b1, 32'h200, 6'h04, 6'h3D};
    tbl[19] = '{C_REGW | C_MTR | C_RDST,     2'b00, 3'b000, 32'h0000_0000, 32'h200, 32'h6, 1'b0, 1'b1, 32'h200, 6'h04, 6'h3D};
    // slt $9,$9,$8 with $9=-1, $8=1
    tbl[20] = '{C_IRW,                       2'b00, 3'b000, 32'h0128_482A, 32'h200, 32'h6, 1'b0, 1'b1, 32'h200, 6'h04, 6'h3D};
    tbl[21] = '{C_NONE,                      2'b00, 3'b000, 32'hFFFF_FFFF, 32'h200, 32'h6, 1'b0, 1'b1, 32'h200, 6'h00, 6'h2A};
    tbl[22] = '{C_REGW | C_MTR | C_RDST,     2'b00, 3'b000, 32'h0000_0001, 32'h200, 32'h5, 1'b0, 1'b1, 32'h200, 6'h00, 6'h2A};
    tbl[23] = '{C_REGW | C_MTR,              2'b00, 3'b000, 32'h0000_0000, 32'h200, 32'h5, 1'b0, 1'b1, 32'h200, 6'h00, 6'h2A};
    tbl[24] = '{C_NONE,                      2'b00, 3'b000, 32'h0000_0000, 32'h200, 32'h5, 1'b0, 1'b1, 32'h200, 6'h00, 6'h2A};
    tbl[25] = '{C_ASRCA,                     2'b00, 3'b111, 32'h0000_0000, 32'h200, 32'h1, 1'b0, 1'b0, 32'h200, 6'h00, 6'h2A};
    tbl[26] = '{C_ASRCA,                     2'b00, 3'b100, 32'h0000_0000, 32'h200, 32'h1, 1'b0, 1'b1, 32'h200, 6'h00, 6'h2A};
    tbl[27] = '{C_ASRCA,                     2'b00, 3'b000, 32'h0000_0000, 32'h200, 32'h1, 1'b0, 1'b0, 32'h200, 6'h00, 6'h2A};
    // $8 <= 0x12345678, $9 <= 0x40, ALUOut <= 0x40, then store and reset over the store
    tbl[28] = '{C_NONE,                      2'b00, 3'b000, 32'h1234_5678, 32'h200, 32'h1, 1'b0, 1'b1, 32'h200, 6'h00, 6'h2A};
    tbl[29] = '{C_REGW | C_MTR,              2'b00, 3'b000, 32'h0000_0040, 32'h200, 32'h1, 1'b0, 1'b1, 32'h200, 6'h00, 6'h2A};
    tbl[30] = '{C_REGW | C_MTR | C_RDST,     2'b00, 3'b000, 32'h0000_0000, 32'h200, 32'h1, 1'b0, 1'b1, 32'h200, 6'h00, 6'h2A};
    tbl[31] = '{C_NONE,                      2'b00, 3'b000, 32'h0000_0000, 32'h200, 32'h1234_5678, 1'b0, 1'b0, 32'h200, 6'h00, 6'h2A};
    tbl[32] = '{C_ASRCA,                     2'b00, 3'b000, 32'h0000_0000, 32'h200, 32'h1234_5678, 1'b0, 1'b0, 32'h200, 6'h00, 6'h2A};
    tbl[33] = '{C_IORD | C_MEMW | C_ASRCA,   2'b00, 3'b000, 32'h0000_0000, 32'h040, 32'h1234_5678, 1'b1, 1'b0, 32'h200, 6'h00, 6'h2A};
    tbl[34] = '{C_RST | C_IORD | C_MEMW | C_PCW | C_REGW | C_ASRCA, 2'b00, 3'b010, 32'h0000_0000, 32'h040, 32'h1234_5678, 1'b0, 1'b0, 32'h200, 6'h00, 6'h2A};
    // refetch from RESET_PC, cleared $8, write to $0 ignored
    tbl[35] = '{C_IRW | C_PCW,               2'b01, 3'b010, 32'h0100_0020, 32'h100, 32'h0, 1'b0, 1'b0, 32'h100, 6'h00, 6'h00};
    tbl[36] = '{C_ASRCA,                     2'b00, 3'b001, 32'hDEAD_BEEF, 32'h104, 32'h0, 1'b0, 1'b1, 32'h104, 6'h00, 6'h20};
    tbl[37] = '{C_REGW | C_MTR | C_RDST | C_ASRCA, 2'b00, 3'b001, 32'h0000_0000, 32'h104, 32'h0, 1'b0, 1'b1, 32'h104, 6'h00, 6'h20};
    tbl[38] = '{C_ASRCA,                     2'b00, 3'b001, 32'h0000_0000, 32'h104, 32'h0, 1'b0, 1'b1, 32'h104, 6'h00, 6'h20};
    tbl[39] = '{C_ASRCA,                     2'b00, 3'b001, 32'h0000_0000, 32'h104, 32'h0, 1'b0, 1'b1, 32'h104, 6'h00, 6'h20};

`ifdef MC_DATAPATH_JUMP_EN
    Jump = 1'b0;
`endif
    {MemtoReg, RegDst, IorD, PCSrc, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite} = 10'd0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    mem_rdata  = 32'h0000_0000;
    rst        = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 40; i++) begin
      apply(tbl[i], i);
    end

    // PC wrap: $8 <= 0xFFFFFFFC, PCWrite with Branch high loads it, then +4 wraps to 0
    h = '{C_IRW,                 2'b00, 3'b000, 32'h0108_0000, 32'h104, 32'h0, 1'b0, 1'b1, 32'h104, 6'h00, 6'h20};
    apply(h, 100);
    h = '{C_NONE,                2'b00, 3'b000, 32'hFFFF_FFFC, 32'h104, 32'h0, 1'b0, 1'b1, 32'h104, 6'h00, 6'h00};
    apply(h, 101);
    h = '{C_REGW | C_MTR,        2'b00, 3'b000, 32'h0000_0000, 32'h104, 32'h0, 1'b0, 1'b1, 32'h104, 6'h00, 6'h00};
    apply(h, 102);
    h = '{C_NONE,                2'b00, 3'b000, 32'h0000_0000, 32'h104, 32'h0, 1'b0, 1'b1, 32'h104, 6'h00, 6'h00};
    apply(h, 103);
    h = '{C_PCW | C_BR | C_ASRCA, 2'b00, 3'b000, 32'h0000_0000, 32'h104, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h104, 6'h00, 6'h00};
    apply(h, 104);
    h = '{C_PCW,                 2'b01, 3'b010, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC, 6'h00, 6'h00};
    apply(h, 105);
    h = '{C_NONE,                2'b00, 3'b000, 32'h0000_0000, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0, 6'h00, 6'h00};
    apply(h, 106);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
